// File: rtl/led_status_array_if.sv
`default_nettype none
// ============================================================================
// Module      : led_status_array_if
// Description : Bundle between the status logic and the LED driver.
//               mode : per-channel 3-bit mode, channel i on [3i+2:3i]
//               code : per-channel blink-code pulse count, channel i on [4i+3:4i]
//               led  : LED pin drive, one bit per channel
//               master drives mode/code and watches led; slave is the driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface led_status_array_if #(
    parameter int NUM_LEDS = 4
);
    logic [3*NUM_LEDS-1:0] mode;
    logic [4*NUM_LEDS-1:0] code;
    logic [NUM_LEDS-1:0]   led;

    modport master (output mode, output code, input led);
    modport slave  (input mode, input code, output led);
endinterface
`default_nettype wire

// File: rtl/led_status_array.sv
`default_nettype none
// ============================================================================
// Module      : led_status_array
// Description : Multi-channel LED status indicator. Every channel selects
//               off, on, slow/medium/fast blink, heartbeat or a repeating
//               blink code. One shared prescaler and phase counter keep all
//               blinking channels in lock-step.
//               clk  : sole clock, rising edge
//               rst  : synchronous, active-high reset
//               bus  : mode/code inputs and led outputs (slave side)
// Revision    : 1.0 - initial release
// ============================================================================
module led_status_array #(
    parameter int NUM_LEDS   = 4,
    parameter int TICK_DIV   = 23,
    parameter int ACTIVE_LOW = 1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    led_status_array_if.slave   bus
);

    localparam logic             c_POL       = (ACTIVE_LOW != 0);
    localparam logic [TICK_DIV-1:0] c_PRE_ONE = {{(TICK_DIV-1){1'b0}}, 1'b1};

    localparam logic [2:0] c_MODE_OFF   = 3'd0;
    localparam logic [2:0] c_MODE_ON    = 3'd1;
    localparam logic [2:0] c_MODE_SLOW  = 3'd2;
    localparam logic [2:0] c_MODE_MED   = 3'd3;
    localparam logic [2:0] c_MODE_FAST  = 3'd4;
    localparam logic [2:0] c_MODE_HEART = 3'd5;
    localparam logic [2:0] c_MODE_CODE  = 3'd6;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_ON   = 2'd1;
    localparam logic [1:0] c_S_OFF  = 2'd2;
    localparam logic [1:0] c_S_GAP  = 2'd3;

    logic [TICK_DIV-1:0]   r_prescale;
    logic                  w_tick;
    logic [3:0]            r_phase;
    logic [3*NUM_LEDS-1:0] r_mode;
    logic [4*NUM_LEDS-1:0] r_code;
    logic [NUM_LEDS-1:0]   w_lit;
    logic [NUM_LEDS-1:0]   r_led;

    assign w_tick  = &r_prescale;
    assign bus.led = r_led;

    // Shared timebase, input registers and polarity-corrected output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescale <= '0;
            r_phase    <= 4'd0;
            r_mode     <= '0;
            r_code     <= '0;
            r_led      <= {NUM_LEDS{c_POL}};
        end else begin
            r_prescale <= r_prescale + c_PRE_ONE;
            if (w_tick) begin
                r_phase <= r_phase + 4'd1;
            end
            r_mode <= bus.mode;
            r_code <= bus.code;
            r_led  <= w_lit ^ {NUM_LEDS{c_POL}};
        end
    end

    generate
        for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
            logic [2:0] w_mode;
            logic [3:0] w_code;
            logic [1:0] r_state;
            logic [1:0] w_state_nxt;
            logic [3:0] r_rem;
            logic [3:0] w_rem_nxt;
            logic [2:0] r_gap;
            logic [2:0] w_gap_nxt;
            logic       w_start;
            logic       w_lit_ch;

            assign w_mode = r_mode[3*i +: 3];
            assign w_code = r_code[4*i +: 4];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state <= c_S_IDLE;
                    r_rem   <= 4'd0;
                    r_gap   <= 3'd0;
                end else begin
                    r_state <= w_state_nxt;
                    r_rem   <= w_rem_nxt;
                    r_gap   <= w_gap_nxt;
                end
            end

            // An expired gap re-enters the sequence on the same tick, so the
            // code is only sampled at sequence start; mid-sequence code
            // changes wait for the next repeat.
            assign w_start = (r_state == c_S_IDLE) ||
                             ((r_state == c_S_GAP) && (r_gap == 3'd0));

            always_comb begin
                w_state_nxt = r_state;
                w_rem_nxt   = r_rem;
                w_gap_nxt   = r_gap;
                if (w_mode != c_MODE_CODE) begin
                    w_state_nxt = c_S_IDLE;
                    w_rem_nxt   = 4'd0;
                end else if (w_tick) begin
                    if (w_start) begin
                        if (w_code == 4'd0) begin
                            w_state_nxt = c_S_GAP;
                            w_gap_nxt   = 3'd7;
                        end else begin
                            w_state_nxt = c_S_ON;
                            w_rem_nxt   = w_code - 4'd1;
                        end
                    end else begin
                        case (r_state)
                            c_S_ON: begin
                                w_state_nxt = c_S_OFF;
                            end
                            c_S_OFF: begin
                                if (r_rem == 4'd0) begin
                                    w_state_nxt = c_S_GAP;
                                    w_gap_nxt   = 3'd7;
                                end else begin
                                    w_state_nxt = c_S_ON;
                                    w_rem_nxt   = r_rem - 4'd1;
                                end
                            end
                            default: begin
                                w_gap_nxt = r_gap - 3'd1;
                            end
                        endcase
                    end
                end
            end

            always_comb begin
                w_lit_ch = 1'b0;
                case (w_mode)
                    c_MODE_OFF:   w_lit_ch = 1'b0;
                    c_MODE_ON:    w_lit_ch = 1'b1;
                    c_MODE_SLOW:  w_lit_ch = r_phase[3];
                    c_MODE_MED:   w_lit_ch = r_phase[2];
                    c_MODE_FAST:  w_lit_ch = r_phase[0];
                    c_MODE_HEART: w_lit_ch = (r_phase == 4'd0) || (r_phase == 4'd2);
                    c_MODE_CODE:  w_lit_ch = (r_state == c_S_ON);
                    default:      w_lit_ch = 1'b0;
                endcase
            end

            assign w_lit[i] = w_lit_ch;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_led_status_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_status_array
// Description : Scoreboard bench for led_status_array (NUM_LEDS=4, TICK_DIV=2,
//               ACTIVE_LOW=1). Stimulus queues expected led values tagged
//               with the cycle they are due; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_status_array;

    localparam int NUM_LEDS   = 4;
    localparam int TICK_DIV   = 2;
    localparam int ACTIVE_LOW = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    led_status_array_if #(.NUM_LEDS(NUM_LEDS)) bus ();

    led_status_array #(
        .NUM_LEDS   (NUM_LEDS),
        .TICK_DIV   (TICK_DIV),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         cyc;
        logic [3:0] mask;
        logic [3:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   st[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // lit is the wanted glow pattern; pins are active low.
    task automatic push(input int c, input logic [3:0] mask, input logic [3:0] lit, input string name);
        sb.push_back('{c, mask, ~lit, name});
    endtask

    // led at k cycles after reset release reflects phase floor(k/4).
    function automatic logic rate_lit(input logic [2:0] m, input int k);
        int p;
        logic r;
        p = (k / 4) % 16;
        r = 1'b0;
        if (k > 0) begin
            case (m)
                3'd2: r = (p >= 8);
                3'd3: r = ((p % 8) >= 4);
                3'd4: r = ((p % 2) == 1);
                3'd5: r = (p == 0) || (p == 2);
                default: r = 1'b0;
            endcase
        end
        return r;
    endfunction

    function automatic logic pulse(input int k);
        logic r;
        r = 1'b0;
        foreach (st[j]) begin
            if (k >= st[j] && k < st[j] + 4) r = 1'b1;
        end
        return r;
    endfunction

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset(input logic [11:0] m, input logic [15:0] c, output int b);
        rst      = 1'b1;
        bus.mode = m;
        bus.code = c;
        push(cyc + 1, 4'hf, 4'h0, "reset_dark");
        @(posedge clk);
        #1;
        rst = 1'b0;
        b   = cyc + 1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_vec++;
            if (e.cyc != cyc) begin
                n_bad++;
                $display("FAIL %s: due at cycle %0d, checked at %0d", e.name, e.cyc, cyc);
            end else if ((bus.led & e.mask) !== (e.exp & e.mask)) begin
                n_bad++;
                $display("FAIL %s @cycle %0d: led=%b expected=%b mask=%b",
                         e.name, cyc, bus.led, e.exp, e.mask);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

    initial begin
        int b;
        int b2;

        // Reset with all channels requesting on: everything stays dark.
        bus.mode = 12'o1111;
        bus.code = 16'h0000;
        push(1, 4'hf, 4'h0, "rst_dark_1");
        push(2, 4'hf, 4'h0, "rst_dark_2");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst      = 1'b0;
        bus.mode = 12'o0001;
        b        = cyc + 1;
        push(b, 4'hf, 4'h0, "static_lat1");
        push(b + 1, 4'hf, 4'b0001, "static_lat2");
        for (int k = 2; k <= 10; k++) push(b + k, 4'hf, 4'b0001, "static_on");
        wait_cyc(b + 10);

        // Rates: ch1 slow, ch2 medium, ch3 fast, ch0 off.
        apply_reset(12'o4320, 16'h0000, b);
        for (int k = 0; k <= 140; k++)
            push(b + k, 4'hf, {rate_lit(3'd4, k), rate_lit(3'd3, k), rate_lit(3'd2, k), 1'b0}, "rates");
        wait_cyc(b + 140);

        // Heartbeat on ch0.
        apply_reset(12'o0005, 16'h0000, b);
        for (int k = 0; k <= 130; k++)
            push(b + k, 4'hf, {3'b000, rate_lit(3'd5, k)}, "heartbeat");
        wait_cyc(b + 130);

        // Blink code 3, switched to 1 during the first pulse.
        apply_reset(12'o0006, 16'h0003, b);
        st = '{4, 12, 20, 60, 100, 140};
        for (int k = 0; k <= 150; k++)
            push(b + k, 4'hf, {3'b000, pulse(k)}, "blink_code");
        wait_cyc(b + 5);
        bus.code = 16'h0001;
        wait_cyc(b + 150);

        // Code 0 stays dark; then code 2, then exit to mode 1 while ON.
        apply_reset(12'o0006, 16'h0000, b);
        for (int k = 0; k <= 100; k++) push(b + k, 4'hf, 4'h0, "code0_dark");
        wait_cyc(b + 100);
        bus.code = 16'h0002;
        for (int k = 101; k <= 131; k++) push(b + k, 4'hf, 4'h0, "code2_wait");
        for (int k = 132; k <= 145; k++) push(b + k, 4'hf, 4'b0001, "code_exit_on");
        wait_cyc(b + 132);
        bus.mode = 12'o0001;
        wait_cyc(b + 145);

        // Reset during the second pulse of code 5, then full restart.
        apply_reset(12'o0006, 16'h0005, b);
        st = '{4, 12};
        for (int k = 0; k <= 13; k++) push(b + k, 4'hf, {3'b000, pulse(k)}, "code5_pre");
        wait_cyc(b + 13);
        apply_reset(12'o0006, 16'h0005, b2);
        st = '{4, 12, 20, 28, 36, 76, 84, 92, 100};
        for (int k = 0; k <= 100; k++) push(b2 + k, 4'hf, {3'b000, pulse(k)}, "code5_restart");
        wait_cyc(b2 + 100);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
